// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
// Holds the frame FSM encoding, the key-event record and the prefix bytes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Odd parity over the data byte plus the transmitted parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with wrap-bit pointers and a registered fill level.
// The read port shows the head entry, forced to zero while the FIFO is empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = ps2_event_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  T                         wdata_i,
  input  logic                     pop_i,
  output T                         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne  = (AW + 1)'(1);
  localparam logic [AW:0] FullXor = {1'b1, {AW{1'b0}}};

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] level_q, level_d;
  T            mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wptr_q ^ rptr_q) == FullXor;
  assign empty_o = (wptr_q == rptr_q);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrOne;
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + PtrOne;
      2'b01:   level_d = level_q - PtrOne;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    rdata_o = '0;
    if (!empty_o) begin
      rdata_o = mem_q[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises kClock/kData, frames 11-bit packets, folds
// E0/F0 prefixes into per-key events and queues them for a valid/ready consumer.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          PARITY_CHECK   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          kClock,
  input  logic                          kData,
  output logic [7:0]                    out_code,
  output logic                          out_brk,
  output logic                          out_ext,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TmoEnd = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [SYNC_STAGES-1:0] kclk_sync_q;
  logic [SYNC_STAGES-1:0] kdat_sync_q;
  logic                   kclk_prev_q;
  logic                   kclk_s;
  logic                   kdat_s;
  logic                   fall;

  ps2_state_t state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q;
  logic          err_q, err_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;

  logic       push;
  ps2_event_t push_ev;
  ps2_event_t head_ev;
  logic       fifo_full;
  logic       fifo_empty;

  assign kclk_s = kclk_sync_q[SYNC_STAGES-1];
  assign kdat_s = kdat_sync_q[SYNC_STAGES-1];
  assign fall   = kclk_prev_q & ~kclk_s;

  // Synchronisers idle high so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
      kclk_prev_q <= 1'b1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], kClock};
      kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], kData};
      kclk_prev_q <= kclk_s;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (!fall && (state_q != IDLE)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Abandon the frame on the edge where the idle count reaches TIMEOUT_CYCLES-1.
  assign tmo = (state_q != IDLE) && (cnt_d == TmoEnd);

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall && !kdat_s) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_d  = {kdat_s, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = kdat_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (kdat_s && (!PARITY_CHECK || odd_parity_ok(shreg_q, par_q))) begin
            byte_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  // Prefix decoder: E0/F0 only set flags, any other byte becomes an event.
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    push         = 1'b0;
    push_ev.ext  = ext_q;
    push_ev.brk  = brk_q;
    push_ev.code = byte_q;
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      err_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      byte_vld_q <= byte_vld_d;
      err_q      <= err_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      if (byte_vld_d) begin
        byte_q <= shreg_q;
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .T    (ps2_event_t)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push),
    .wdata_i(push_ev),
    .pop_i  (out_ready),
    .rdata_o(head_ev),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  assign out_valid = ~fifo_empty;
  assign out_code  = head_ev.code;
  assign out_brk   = head_ev.brk;
  assign out_ext   = head_ev.ext;
  assign frame_err = err_q;
  assign overflow  = push & fifo_full & ~(out_ready & ~fifo_empty);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: frame-level reference model plus
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_ps2_scancode_rx;

  localparam int unsigned S  = 2;
  localparam int unsigned TC = 200;
  localparam int unsigned D  = 4;
  localparam int unsigned H  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kClock = 1'b1;
  logic       kData = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_code;
  logic       out_brk;
  logic       out_ext;
  logic       out_valid;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  ps2_scancode_rx #(
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(TC),
    .FIFO_DEPTH    (D),
    .PARITY_CHECK  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kClock    (kClock),
    .kData     (kData),
    .out_code  (out_code),
    .out_brk   (out_brk),
    .out_ext   (out_ext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  typedef struct {
    int         due;
    bit         good;
    logic [7:0] b;
  } pend_t;

  pend_t      pend[$];
  logic [9:0] model_q[$];
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fall_cyc = 0;
  int   stop_fall_cyc = 0;
  int   err_seen = 0;
  int   ovf_seen = 0;
  int   last_err_cyc = -1;
  int   rise_cyc = -1;
  bit   prev_valid = 1'b0;
  bit   cmp_en = 1'b0;
  bit   done = 1'b0;
  event stop_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: pops on ready, then applies the frame whose decode cycle ends now.
  always @(posedge clk) begin : model_upd
    int    idx;
    int    sz;
    bit    popped;
    pend_t p;
    if (!rst) begin
      model_q.delete();
      pend.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      sz     = model_q.size();
      popped = out_ready && (sz > 0);
      if (popped) void'(model_q.pop_front());
      idx = -1;
      foreach (pend[i]) if (pend[i].due == cyc) idx = i;
      if (idx >= 0) begin
        p = pend[idx];
        pend.delete(idx);
        if (!p.good) begin
          m_ext = 1'b0;
          m_brk = 1'b0;
        end else if (p.b == 8'hE0) begin
          m_ext = 1'b1;
        end else if (p.b == 8'hF0) begin
          m_brk = 1'b1;
        end else begin
          if ((sz < int'(D)) || popped) model_q.push_back({m_ext, m_brk, p.b});
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    bit e_err;
    bit e_ovf;
    if (cmp_en && rst) begin
      e_err = 1'b0;
      e_ovf = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          if (!pend[i].good) e_err = 1'b1;
          else if (pend[i].b != 8'hE0 && pend[i].b != 8'hF0 &&
                   model_q.size() == int'(D) && !out_ready) e_ovf = 1'b1;
        end
      end
      chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      chk("fifo_level", 32'(fifo_level), 32'(model_q.size()));
      chk("frame_err", 32'(frame_err), 32'(e_err));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      if (model_q.size() > 0) chk("head_event", 32'({out_ext, out_brk, out_code}), 32'(model_q[0]));
      if (frame_err) begin
        err_seen++;
        last_err_cyc = cyc;
      end
      if (overflow) ovf_seen++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nfalls, input bit track);
    logic [10:0] bits;
    logic        par;
    pend_t       p;
    par  = ~(^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      @(negedge clk);
      kData = bits[i];
      repeat (H) @(negedge clk);
      kClock   = 1'b0;
      fall_cyc = cyc;
      if (i == 10) begin
        p.due  = cyc + int'(S) + 1;
        p.good = bits[10] && (^bits[9:1]);
        p.b    = b;
        pend.push_back(p);
        stop_fall_cyc = cyc;
        ->stop_ev;
      end
      repeat (H) @(negedge clk);
      kClock = 1'b1;
    end
    if (track && nfalls < 11) begin
      p.due  = fall_cyc + int'(S) + int'(TC);
      p.good = 1'b0;
      p.b    = 8'h00;
      pend.push_back(p);
    end
    @(negedge clk);
    kData = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2;
    out_ready = v;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
    summary();
    $finish;
  end

  initial begin : main
    logic [7:0] pops [4];
    int e0;
    int o0;
    int tf;
    int due;
    pops[0] = 8'h1C; pops[1] = 8'h32; pops[2] = 8'h21; pops[3] = 8'h23;

    repeat (3) @(negedge clk);
    chk("rst_code", 32'(out_code), 32'h0);
    chk("rst_brk", 32'(out_brk), 32'h0);
    chk("rst_ext", 32'(out_ext), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    @(posedge clk);
    #2;
    rst    = 1'b1;
    cmp_en = 1'b1;
    repeat (5) @(negedge clk);

    // Single make code and its stop-fall to out_valid latency.
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b1);
    settle();
    chk("lat_1C", 32'(rise_cyc), 32'(stop_fall_cyc + 4));
    chk("head_1C", 32'({out_ext, out_brk, out_code}), 32'h01C);
    chk("level_1C", 32'(fifo_level), 32'h1);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    chk("pop_1C", 32'(fifo_level), 32'h0);

    send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b1);
    settle();
    chk("head_F0_1C", 32'({out_ext, out_brk, out_code}), 32'h11C);
    chk("level_F0_1C", 32'(fifo_level), 32'h1);
    set_ready(1'b1);
    set_ready(1'b0);

    send_frame(8'hE0, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0, 11, 1'b1);
    settle();
    chk("head_E0_F0_75", 32'({out_ext, out_brk, out_code}), 32'h375);
    chk("level_E0_F0_75", 32'(fifo_level), 32'h1);
    set_ready(1'b1);
    set_ready(1'b0);

    e0 = err_seen;
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b1);
    settle();
    chk("parity_err_pulse", 32'(err_seen - e0), 32'h1);
    chk("parity_no_event", 32'(fifo_level), 32'h0);
    e0 = err_seen;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    settle();
    chk("stop_err_pulse", 32'(err_seen - e0), 32'h1);
    chk("stop_no_event", 32'(fifo_level), 32'h0);

    // Stalled frame after an E0 prefix; the timeout must also drop the prefix.
    send_frame(8'hE0, 1'b0, 1'b0, 11, 1'b1);
    e0 = err_seen;
    send_frame(8'h55, 1'b0, 1'b0, 6, 1'b1);
    tf = fall_cyc;
    repeat (TC + 20) @(negedge clk);
    chk("timeout_pulse", 32'(err_seen - e0), 32'h1);
    chk("timeout_cycle", 32'(last_err_cyc), 32'(tf + 2 + 200));
    send_frame(8'h29, 1'b0, 1'b0, 11, 1'b1);
    settle();
    chk("head_after_tmo", 32'({out_ext, out_brk, out_code}), 32'h029);
    set_ready(1'b1);
    set_ready(1'b0);

    // Fill past capacity with the consumer stalled.
    o0 = ovf_seen;
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h32, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h21, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h23, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h24, 1'b0, 1'b0, 11, 1'b1);
    settle();
    chk("full_level", 32'(fifo_level), 32'h4);
    chk("ovf_pulse", 32'(ovf_seen - o0), 32'h1);
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pop_order", 32'({out_valid, out_code}), 32'({1'b1, pops[i]}));
    end
    set_ready(1'b0);
    @(negedge clk);
    chk("drained_level", 32'(fifo_level), 32'h0);

    // Full FIFO with a pop in the very cycle the new event is written.
    send_frame(8'h11, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h12, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h13, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h14, 1'b0, 1'b0, 11, 1'b1);
    settle();
    o0 = ovf_seen;
    fork
      send_frame(8'h24, 1'b0, 1'b0, 11, 1'b1);
      begin
        @(stop_ev);
        due = stop_fall_cyc + int'(S) + 1;
        while (cyc != due) begin
          @(posedge clk);
          #2;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
      end
    join
    settle();
    chk("simul_level", 32'(fifo_level), 32'h4);
    chk("simul_no_ovf", 32'(ovf_seen - o0), 32'h0);
    chk("simul_head", 32'({out_ext, out_brk, out_code}), 32'h012);
    set_ready(1'b1);
    repeat (6) @(negedge clk);
    set_ready(1'b0);

    // Reset in the middle of a frame, with a pending F0 prefix.
    send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b1);
    send_frame(8'h33, 1'b0, 1'b0, 5, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_level", 32'(fifo_level), 32'h0);
    chk("midrst_err", 32'(frame_err), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1);
    settle();
    chk("head_after_rst", 32'({out_ext, out_brk, out_code}), 32'h05A);
    chk("level_after_rst", 32'(fifo_level), 32'h1);
    set_ready(1'b1);
    set_ready(1'b0);

    // Random traffic with random back-pressure, checked by the model each cycle.
    fork
      begin
        logic [7:0] b;
        int         r;
        for (int n = 0; n < 30; n++) begin
          r = int'($urandom_range(0, 9));
          b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
          send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 11, 1'b1);
          repeat ($urandom_range(2, 20)) @(negedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join

    set_ready(1'b1);
    repeat (40) @(negedge clk);
    chk("final_level", 32'(fifo_level), 32'h0);
    chk("final_valid", 32'(out_valid), 32'h0);
    summary();
    $finish;
  end

endmodule
